// File: rtl/video_frame_monitor_pkg.sv
// Purpose: shared types, widths and helpers for the video frame monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, accumulator/stat widths, RGB pixel layout,
// saturating arithmetic helpers used by the accumulators.
package video_frame_monitor_pkg;

  localparam int SUM_W  = 27;   // per-channel frame sum
  localparam int CNT_W  = 11;   // pixel-in-line and line counters
  localparam int FCNT_W = 16;   // completed-frame counter
  localparam int PIX_W  = 24;   // one RGB888 pixel

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    REPORT = 2'd2
  } state_t;

  // Pixel layout on video_data: {R[23:16], G[15:8], B[7:0]}.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Everything that is cleared together at frame boundaries.
  typedef struct packed {
    logic [SUM_W-1:0] sum_r;
    logic [SUM_W-1:0] sum_g;
    logic [SUM_W-1:0] sum_b;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] line_cnt;
    logic             line_err;
  } acc_t;

  // Add one 8-bit channel sample, clamping at all-ones instead of wrapping.
  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] s,
                                               input logic [7:0]       v);
    logic [SUM_W:0] t;
    t = {1'b0, s} + {{(SUM_W + 1 - 8){1'b0}}, v};
    return t[SUM_W] ? {SUM_W{1'b1}} : t[SUM_W-1:0];
  endfunction

  // Counter increment that sticks at its maximum.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/video_frame_monitor_if.sv
// Purpose: bundles the incoming video timing/pixel stream and the per-frame stats.
// Latency: n/a (wiring only).
// Backpressure: none; the video source is free-running and the stats are a pulse.
//
// master: video source / stats consumer (drives video_*, reads stat_*/frame_cnt)
// slave : the monitor (reads video_*, drives stat_*/frame_cnt)
interface video_frame_monitor_if;
  import video_frame_monitor_pkg::*;

  logic              video_vsync;
  logic              video_hsync;
  logic              video_de;
  logic [PIX_W-1:0]  video_data;

  logic              stat_valid;
  logic [SUM_W-1:0]  stat_sum_r;
  logic [SUM_W-1:0]  stat_sum_g;
  logic [SUM_W-1:0]  stat_sum_b;
  logic [CNT_W-1:0]  stat_pix_lines;
  logic              stat_line_err;
  logic              stat_frame_err;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (
    output video_vsync, video_hsync, video_de, video_data,
    input  stat_valid, stat_sum_r, stat_sum_g, stat_sum_b,
    input  stat_pix_lines, stat_line_err, stat_frame_err, frame_cnt
  );

  modport slave (
    input  video_vsync, video_hsync, video_de, video_data,
    output stat_valid, stat_sum_r, stat_sum_g, stat_sum_b,
    output stat_pix_lines, stat_line_err, stat_frame_err, frame_cnt
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Purpose: one-cycle pulses on vsync rising edge and hsync falling edge (line end).
// Latency: combinational against the one-cycle registered copy of each sync.
// Backpressure: none.
//
// Ports: clk, rst_n (async, active low); vsync, hsync in; vs_rise, hs_fall out.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  input  logic hsync,
  output logic vs_rise,
  output logic hs_fall
);

  logic vs_d;
  logic hs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d <= 1'b0;
      hs_d <= 1'b0;
    end else begin
      vs_d <= vsync;
      hs_d <= hsync;
    end
  end

  assign vs_rise = vsync & ~vs_d;
  assign hs_fall = ~hsync & hs_d;

endmodule

// File: rtl/video_frame_monitor.sv
// Purpose: per-frame RGB sums, line counting and geometry checking of a video stream.
// Latency: stats valid 2 cycles after vsync is first sampled high; held until next report.
// Backpressure: none; observes the stream only and never stalls it.
//
// Ports: clk, rst_n (async, active low); vif (slave) carries video_vsync/hsync/de/data
// in and stat_valid, stat_sum_r/g/b, stat_pix_lines, stat_line_err, stat_frame_err,
// frame_cnt out. IMG_HDISP/IMG_VDISP give the expected frame geometry.
module video_frame_monitor
  import video_frame_monitor_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic                 clk,
  input  logic                 rst_n,
  video_frame_monitor_if.slave vif
);

  localparam logic [CNT_W-1:0] HDISP_C = CNT_W'(IMG_HDISP);
  localparam logic [CNT_W-1:0] VDISP_C = CNT_W'(IMG_VDISP);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic   vs_rise;
  logic   hs_fall;
  logic   pix_ok;
  rgb_t   px;
  state_t state;
  acc_t   acc;

  sync_edge_detect u_sync_edge_detect (
    .clk     (clk),
    .rst_n   (rst_n),
    .vsync   (vif.video_vsync),
    .hsync   (vif.video_hsync),
    .vs_rise (vs_rise),
    .hs_fall (hs_fall)
  );

  assign px = vif.video_data;

  // Only pixels inside an active line and outside vertical sync count.
  assign pix_ok = vif.video_de & vif.video_hsync & ~vif.video_vsync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      acc                <= '0;
      vif.stat_valid     <= 1'b0;
      vif.stat_sum_r     <= '0;
      vif.stat_sum_g     <= '0;
      vif.stat_sum_b     <= '0;
      vif.stat_pix_lines <= '0;
      vif.stat_line_err  <= 1'b0;
      vif.stat_frame_err <= 1'b0;
      vif.frame_cnt      <= '0;
    end else begin
      vif.stat_valid <= 1'b0;
      case (state)
        // Out of reset we have no idea where in the frame we are, so the
        // first vsync only opens a measurement window.
        IDLE: begin
          if (vs_rise) begin
            acc   <= '0;
            state <= ACTIVE;
          end
        end

        ACTIVE: begin
          if (pix_ok) begin
            acc.sum_r   <= sat_add(acc.sum_r, px.r);
            acc.sum_g   <= sat_add(acc.sum_g, px.g);
            acc.sum_b   <= sat_add(acc.sum_b, px.b);
            acc.pix_cnt <= sat_inc(acc.pix_cnt);
          end
          // pix_ok needs hsync high and hs_fall needs it low, so the two
          // never update pix_cnt in the same cycle.
          if (hs_fall) begin
            acc.line_cnt <= sat_inc(acc.line_cnt);
            if ((acc.pix_cnt != HDISP_C) || (acc.pix_cnt == CNT_MAX)) begin
              acc.line_err <= 1'b1;
            end
            acc.pix_cnt <= '0;
          end
          // A line end in the same cycle lands in acc at this edge, so
          // REPORT sees it.
          if (vs_rise) begin
            state <= REPORT;
          end
        end

        REPORT: begin
          vif.stat_valid     <= 1'b1;
          vif.stat_sum_r     <= acc.sum_r;
          vif.stat_sum_g     <= acc.sum_g;
          vif.stat_sum_b     <= acc.sum_b;
          vif.stat_pix_lines <= acc.line_cnt;
          vif.stat_line_err  <= acc.line_err;
          vif.stat_frame_err <= (acc.line_cnt != VDISP_C) | acc.line_err;
          vif.frame_cnt      <= vif.frame_cnt + 1'b1;
          acc                <= '0;
          state              <= ACTIVE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
